// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scanner with debounce, multi-key reject and auto-repeat
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   row_n         active-low row returns (asynchronous, synchronised internally)
//   col_n         active-low column strobes, exactly one bit low
//   key_code      code of last accepted key, held until the next accept
//   key_valid     one-cycle pulse per accepted press or auto-repeat
//   key_held      high while the accepted key remains pressed
//   key_released  one-cycle pulse when the release is accepted
//   multi_key     one-cycle pulse when a scan sample sees more than one row low
module keypad_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_CYCLES    = 1000,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int REPEAT_PERIODS = 0,
  parameter int MAP_HEX        = 1,
  parameter int CODE_W         = MAP_HEX != 0 ? 4 : (ROWS * COLS > 2 ? $clog2(ROWS * COLS) : 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   row_n,
  output logic [COLS-1:0]   col_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              key_released,
  output logic              multi_key
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int TW = $clog2(SCAN_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int PW = REPEAT_PERIODS > 0 ? $clog2(REPEAT_PERIODS + 1) : 1;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  if (MAP_HEX != 0 && (ROWS != 4 || COLS != 4)) begin : g_bad_map
    $error("keypad_scanner: MAP_HEX=1 requires ROWS=COLS=4");
  end

  state_t            state_q, state_d;
  logic [ROWS-1:0]   sync_q, rows_q;
  logic [TW-1:0]     dwell_q;
  logic [CW-1:0]     col_q, col_d, col_nx;
  logic [RW-1:0]     cand_q, cand_d, row_idx;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     rep_q, rep_d;
  logic [CODE_W-1:0] code_q, acc_code;
  logic              valid_q, held_q, rel_q, multi_q;
  logic [ROWS-1:0]   low;
  logic              sample, any_low, one_low, cand_low, only_cand;
  logic              accept, rpt, rls, multi;

  assign low       = ~rows_q;
  assign sample    = dwell_q == TW'(SCAN_CYCLES - 1);
  assign any_low   = |low;
  assign one_low   = any_low && ((low & (low - ROWS'(1))) == '0);
  assign cand_low  = low[cand_q];
  assign only_cand = low == (ROWS'(1) << cand_q);
  assign col_nx    = col_q == CW'(COLS - 1) ? '0 : col_q + CW'(1);

  always_comb begin
    row_idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) if (low[r]) row_idx = RW'(r);
  end

  // On accept row_idx is the candidate row: in DEBOUNCE only that row may be low.
  if (MAP_HEX != 0) begin : g_hex
    localparam logic [63:0] HEX_MAP = 64'hDF0EC987B654A321;
    assign acc_code = CODE_W'(HEX_MAP[{row_idx, col_q, 2'b00} +: 4]);
  end else begin : g_raw
    assign acc_code = CODE_W'(int'(row_idx) * COLS + int'(col_q));
  end

  // Event decisions, all taken on a sample point.
  always_comb begin
    accept = sample && ((state_q == SCAN && one_low && DEBOUNCE_SCANS == 1) ||
                        (state_q == DEBOUNCE && only_cand && cnt_q == DW'(DEBOUNCE_SCANS - 1)));
    rpt    = sample && state_q == HELD && cand_low && REPEAT_PERIODS != 0 &&
             rep_q == PW'(REPEAT_PERIODS - 1);
    rls    = sample && !cand_low && ((state_q == HELD && DEBOUNCE_SCANS == 1) ||
                                     (state_q == RELEASE && cnt_q == DW'(DEBOUNCE_SCANS - 1)));
    multi  = sample && state_q == SCAN && any_low && !one_low;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    if (sample) begin
      case (state_q)
        SCAN: begin
          if (one_low) begin
            cand_d  = row_idx;
            cnt_d   = accept ? '0 : DW'(1);
            rep_d   = '0;
            state_d = accept ? HELD : DEBOUNCE;
          end else col_d = col_nx;
        end
        DEBOUNCE: begin
          if (!only_cand) begin
            state_d = SCAN;
            col_d   = col_nx;
          end else begin
            cnt_d   = accept ? '0 : cnt_q + DW'(1);
            rep_d   = '0;
            state_d = accept ? HELD : DEBOUNCE;
          end
        end
        HELD: begin
          if (cand_low) begin
            cnt_d = '0;
            rep_d = (rpt || REPEAT_PERIODS == 0) ? '0 : rep_q + PW'(1);
          end else if (rls) begin
            state_d = SCAN;
            col_d   = '0;
            cnt_d   = '0;
            rep_d   = '0;
          end else begin
            cnt_d   = DW'(1);
            state_d = RELEASE;
          end
        end
        default: begin
          if (cand_low) begin
            state_d = HELD;
            cnt_d   = '0;
            rep_d   = '0;
          end else if (rls) begin
            state_d = SCAN;
            col_d   = '0;
            cnt_d   = '0;
            rep_d   = '0;
          end else cnt_d = cnt_q + DW'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCAN;
      sync_q  <= '1;
      rows_q  <= '1;
      dwell_q <= '0;
      col_q   <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      rel_q   <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= row_n;
      rows_q  <= sync_q;
      dwell_q <= sample ? '0 : dwell_q + TW'(1);
      col_q   <= col_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      code_q  <= accept ? acc_code : code_q;
      valid_q <= accept | rpt;
      held_q  <= accept ? 1'b1 : rls ? 1'b0 : held_q;
      rel_q   <= rls;
      multi_q <= multi;
    end
  end

  assign col_n        = ~(COLS'(1) << col_q);
  assign key_code     = code_q;
  assign key_valid    = valid_q;
  assign key_held     = held_q;
  assign key_released = rel_q;
  assign multi_key    = multi_q;
endmodule
